// File: rtl/phase_a_fsub_if.sv
// Operand/result bundle between phase_a and its final conditional-subtraction stage.
interface phase_a_fsub_if #(
    parameter int W = 3072
);
    logic [W-1:0] a;
    logic [W-1:0] m;
    logic         en;
    logic [W-1:0] new_a;
    logic         en_out;
    logic         busy;

    modport master (
        output a, m, en,
        input  new_a, en_out, busy
    );

    modport slave (
        input  a, m, en,
        output new_a, en_out, busy
    );
endinterface

// File: rtl/phase_a_fsub.sv
// Final reduction of phase_a's result from [0, 2m) into [0, m) using a limb-serial
// subtract, so no full-width carry chain is ever built.
module phase_a_fsub #(
    parameter int W  = 3072,
    parameter int CW = 64
) (
    input  logic           clk,
    input  logic           rst,
    phase_a_fsub_if.slave  bus
);
    localparam int N    = W / CW;
    localparam int CNTW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    state_t          state;
    logic [CNTW-1:0] cnt;
    logic            borrow;
    logic [W-1:0]    xr;
    logic [W-1:0]    mr;
    logic [W-1:0]    dr;
    logic [CW:0]     diff;

    // One limb of x - m - borrow; bit CW is the borrow into the next limb.
    always_comb begin
        diff = {1'b0, xr[CW*int'(cnt) +: CW]}
             - {1'b0, mr[CW*int'(cnt) +: CW]}
             - {{CW{1'b0}}, borrow};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            borrow     <= 1'b0;
            xr         <= '0;
            mr         <= '0;
            dr         <= '0;
            bus.new_a  <= '0;
            bus.en_out <= 1'b0;
            bus.busy   <= 1'b0;
        end else begin
            bus.en_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        xr       <= bus.a;
                        mr       <= bus.m;
                        cnt      <= '0;
                        borrow   <= 1'b0;
                        bus.busy <= 1'b1;
                        state    <= SUB;
                    end
                end
                SUB: begin
                    dr[CW*int'(cnt) +: CW] <= diff[CW-1:0];
                    borrow <= diff[CW];
                    cnt    <= cnt + CNTW'(1);
                    if (cnt == CNTW'(N - 1))
                        state <= DONE;
                end
                DONE: begin
                    // A surviving borrow means x < m, so x passes through unchanged.
                    bus.new_a  <= borrow ? xr : dr;
                    bus.en_out <= 1'b1;
                    bus.busy   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_phase_a_fsub.sv
// Randomized self-checking bench for phase_a_fsub against a whole-number reference.
module tb_phase_a_fsub;
    localparam int W   = 3072;
    localparam int CW  = 64;
    localparam int N   = W / CW;
    localparam int LAT = N + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    phase_a_fsub_if #(.W(W)) bus ();

    phase_a_fsub #(.W(W), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    function automatic logic [W-1:0] ref_fsub(input logic [W-1:0] x, input logic [W-1:0] mm);
        return (x >= mm) ? x - mm : x;
    endfunction

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] v;
        for (int j = 0; j < W / 32; j++) v[j*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the caller just after capture edge k.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] mm);
        bus.a  = x;
        bus.m  = mm;
        bus.en = 1'b1;
        tick();
        bus.en = 1'b0;
    endtask

    // lat = edges after capture edge k at which en_out is first seen; -1 on timeout.
    task automatic wait_done(input int start, output int lat, output bit busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        for (int i = start + 1; i <= start + 4 * N; i++) begin
            tick();
            if (bus.en_out === 1'b1) begin
                lat = i;
                if (bus.busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        int pulses;
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (bus.new_a !== '0) begin
            miscompares++;
            $display("FAIL reset_new_a: got %h want 0", bus.new_a[63:0]);
        end
        vectors++;
        if (bus.en_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_en_out: got %b want 0", bus.en_out);
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        rst = 1'b0;
        pulses = 0;
        repeat (100) begin
            tick();
            if (bus.en_out === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL idle_en_out: got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] xs[5];
        logic [W-1:0] ms[5];
        logic [W-1:0] exp_v;
        logic [W-1:0] tmp;
        int lat;
        bit busy_ok;
        xs[0] = W'(5); ms[0] = W'(3);
        xs[1] = W'(3); ms[1] = W'(5);
        tmp   = {16'hdc85, {190{16'h5a3c}}, 16'hd004};
        xs[2] = tmp;   ms[2] = tmp;
        tmp = '0; tmp[W-1] = 1'b1;
        xs[3] = tmp;   ms[3] = W'(1);
        tmp = '0; tmp[64] = 1'b1;
        xs[4] = tmp;   tmp[0] = 1'b1; ms[4] = tmp;
        for (int t = 0; t < 5; t++) begin
            exp_v = ref_fsub(xs[t], ms[t]);
            start_op(xs[t], ms[t]);
            wait_done(0, lat, busy_ok);
            vectors++;
            if (lat != LAT) begin
                miscompares++;
                $display("FAIL basic%0d_latency: got %0d want %0d", t, lat, LAT);
            end
            vectors++;
            if (bus.new_a !== exp_v) begin
                miscompares++;
                $display("FAIL basic%0d_result: got ..%h top %h want ..%h top %h", t,
                         bus.new_a[63:0], bus.new_a[W-1 -: 64], exp_v[63:0], exp_v[W-1 -: 64]);
            end
            vectors++;
            if (!busy_ok) begin
                miscompares++;
                $display("FAIL basic%0d_busy: got wrong busy profile want high until done", t);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [W-1:0] mm, x, exp_v;
        logic [W:0] xw;
        int lat;
        bit busy_ok;
        for (int t = 0; t < 200; t++) begin
            mm = rand_wide();
            mm[0] = 1'b1;
            mm[W-1] = 1'b0;
            xw = {1'b0, rand_wide()} % {mm, 1'b0};
            x = xw[W-1:0];
            exp_v = ref_fsub(x, mm);
            start_op(x, mm);
            wait_done(0, lat, busy_ok);
            vectors++;
            if (lat != LAT) begin
                miscompares++;
                $display("FAIL rand%0d_latency: got %0d want %0d", t, lat, LAT);
            end
            vectors++;
            if (bus.new_a !== exp_v) begin
                miscompares++;
                $display("FAIL rand%0d_result: got ..%h want ..%h", t, bus.new_a[63:0], exp_v[63:0]);
            end
            tick();
            vectors++;
            if (bus.en_out !== 1'b0) begin
                miscompares++;
                $display("FAIL rand%0d_single_pulse: got en_out %b want 0", t, bus.en_out);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [W-1:0] x1, m1, exp_v;
        int lat, pulses;
        bit busy_ok;
        m1 = rand_wide(); m1[W-1] = 1'b0; m1[0] = 1'b1;
        x1 = m1 + rand_wide() % m1;
        exp_v = ref_fsub(x1, m1);
        start_op(x1, m1);
        bus.a = ~x1;
        repeat (9) tick();
        bus.a  = rand_wide();
        bus.m  = rand_wide();
        bus.en = 1'b1;
        tick();
        bus.en = 1'b0;
        wait_done(10, lat, busy_ok);
        vectors++;
        if (lat != LAT) begin
            miscompares++;
            $display("FAIL ignore_latency: got %0d want %0d", lat, LAT);
        end
        vectors++;
        if (bus.new_a !== exp_v) begin
            miscompares++;
            $display("FAIL ignore_result: got ..%h want ..%h", bus.new_a[63:0], exp_v[63:0]);
        end
        pulses = 0;
        repeat (60) begin
            tick();
            if (bus.en_out === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL ignore_extra_en_out: got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x1, m1, x2, m2, e1, e2;
        int lat;
        bit busy_ok;
        m1 = rand_wide(); m1[W-1] = 1'b0; m1[0] = 1'b1;
        x1 = rand_wide() % m1;
        m2 = rand_wide(); m2[W-1] = 1'b0; m2[0] = 1'b1;
        x2 = m2 + rand_wide() % m2;
        e1 = ref_fsub(x1, m1);
        e2 = ref_fsub(x2, m2);
        start_op(x1, m1);
        wait_done(0, lat, busy_ok);
        vectors++;
        if (lat != LAT) begin
            miscompares++;
            $display("FAIL b2b_first_latency: got %0d want %0d", lat, LAT);
        end
        vectors++;
        if (bus.new_a !== e1) begin
            miscompares++;
            $display("FAIL b2b_first_result: got ..%h want ..%h", bus.new_a[63:0], e1[63:0]);
        end
        start_op(x2, m2);
        wait_done(LAT + 1, lat, busy_ok);
        vectors++;
        if (lat != 2 * N + 3) begin
            miscompares++;
            $display("FAIL b2b_second_latency: got %0d want %0d", lat, 2 * N + 3);
        end
        vectors++;
        if (bus.new_a !== e2) begin
            miscompares++;
            $display("FAIL b2b_second_result: got ..%h want ..%h", bus.new_a[63:0], e2[63:0]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] x1, m1, exp_v;
        int lat, pulses;
        bit busy_ok;
        m1 = rand_wide(); m1[W-1] = 1'b0; m1[0] = 1'b1;
        x1 = rand_wide() % m1;
        start_op(x1, m1);
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (bus.new_a !== '0 || bus.en_out !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got new_a ..%h en_out %b busy %b want 0 0 0",
                     bus.new_a[63:0], bus.en_out, bus.busy);
        end
        pulses = 0;
        repeat (60) begin
            tick();
            if (bus.en_out === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL midrst_en_out: got %0d pulses want 0", pulses);
        end
        x1 = m1 + x1;
        exp_v = ref_fsub(x1, m1);
        start_op(x1, m1);
        wait_done(0, lat, busy_ok);
        vectors++;
        if (lat != LAT) begin
            miscompares++;
            $display("FAIL midrst_fresh_latency: got %0d want %0d", lat, LAT);
        end
        vectors++;
        if (bus.new_a !== exp_v) begin
            miscompares++;
            $display("FAIL midrst_fresh_result: got ..%h want ..%h", bus.new_a[63:0], exp_v[63:0]);
        end
    endtask

    initial begin
        rst    = 1'b1;
        bus.a  = '0;
        bus.m  = '0;
        bus.en = 1'b0;
        test_reset();
        test_basic();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
